// File: rtl/obstacle_feeder_pkg.sv
// Shared definitions for the obstacle feeder: FSM encoding, LFSR taps,
// default pacing constants and the LFSR step helper.
package obstacle_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_STOPPED = 2'd3
    } feeder_state_e;

    // Taps for x^8+x^6+x^5+x^4+1: feedback = b7 ^ b5 ^ b4 ^ b3.
    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    // OR-ing the low six bits to 1 lets a reduction-AND yield b7 & b6.
    localparam logic [7:0] LFSR_CAND_MASK = 8'h3F;
    localparam logic [7:0] LFSR_SAFE_SEED = 8'h01;

    localparam int          DEF_DIV_W         = 16;
    localparam logic [15:0] DEF_INIT_PERIOD   = 16'd50000;
    localparam logic [15:0] DEF_MIN_PERIOD    = 16'd10000;
    localparam logic [15:0] DEF_STEP          = 16'd2000;
    localparam int          DEF_SPEEDUP_EVERY = 8;
    localparam int          DEF_MIN_GAP       = 2;
    localparam logic [7:0]  DEF_LFSR_SEED     = 8'hA5;
    localparam logic [3:0]  LEVEL_MAX         = 4'd15;

    // One Fibonacci step: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_feeder_if.sv
// Control/stream bundle between the game controller and the obstacle feeder.
// slave = feeder side, master = controller / shift-register side.
interface obstacle_feeder_if;
    logic       Start;
    logic       Pause;
    logic       Halt;
    logic       BitOut;
    logic       ShiftOut;
    logic       Running;
    logic [3:0] Level;

    modport master (
        output Start, Pause, Halt,
        input  BitOut, ShiftOut, Running, Level
    );

    modport slave (
        input  Start, Pause, Halt,
        output BitOut, ShiftOut, Running, Level
    );
endinterface

// File: rtl/feeder_lfsr8.sv
// 8-bit Fibonacci LFSR that advances only when enabled. A zero seed would
// lock the register at 0, so it is replaced by 8'h01.
module feeder_lfsr8
    import obstacle_feeder_pkg::*;
#(
    parameter logic [7:0] SEED = DEF_LFSR_SEED
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_adv,
    output logic [7:0] o_state
);
    localparam logic [7:0] SEED_SAFE = (SEED == 8'h00) ? LFSR_SAFE_SEED : SEED;

    logic [7:0] r_state;

    // State register: seeded on reset, stepped on each advance request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)   r_state <= SEED_SAFE;
        else if (i_adv) r_state <= lfsr_next(r_state);
    end

    assign o_state = r_state;
endmodule

// File: rtl/obstacle_feeder.sv
// Obstacle feeder: paces shift strobes with a programmable period counter,
// draws obstacle bits from an LFSR subject to a minimum-gap rule, and
// optionally speeds up over time.
// Optional feature macro: FEEDER_SPEEDUP_EN (period shortening and Level).
module obstacle_feeder
    import obstacle_feeder_pkg::*;
#(
    parameter int               DIV_W         = DEF_DIV_W,
    parameter logic [DIV_W-1:0] INIT_PERIOD   = DIV_W'(DEF_INIT_PERIOD),
    parameter logic [DIV_W-1:0] MIN_PERIOD    = DIV_W'(DEF_MIN_PERIOD),
    parameter logic [DIV_W-1:0] STEP          = DIV_W'(DEF_STEP),
    parameter int               SPEEDUP_EVERY = DEF_SPEEDUP_EVERY,
    parameter int               MIN_GAP       = DEF_MIN_GAP,
    parameter logic [7:0]       LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    obstacle_feeder_if.slave     fif
);
    localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(MIN_GAP);

    feeder_state_e    r_state, w_next_state;
    logic [DIV_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
    logic             r_bit;
    logic             r_shift;
    logic             r_running;

    logic             w_start_run;
    logic             w_strobe;
    logic             w_dec;
    logic [7:0]       w_lfsr;
    logic             w_cand;
    logic             w_bit;
    logic [DIV_W-1:0] w_period;
    logic [3:0]       w_level;

    feeder_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .i_clk   (i_Clk),
        .i_rst_n (i_Rst),
        .i_adv   (w_strobe),
        .o_state (w_lfsr)
    );

    // Candidate is b7 & b6 of the pre-step state; suppressed while too close
    // to the previous 1 so the course stays passable.
    assign w_cand = &(w_lfsr | LFSR_CAND_MASK);
    assign w_bit  = w_cand & (r_gap >= GAP_MAX);

    // FSM state register.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next state and pacing actions; Halt beats Pause beats counting.
    always_comb begin
        w_next_state = r_state;
        w_start_run  = 1'b0;
        w_strobe     = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_IDLE, ST_STOPPED: begin
                if (fif.Start) begin
                    w_next_state = ST_RUN;
                    w_start_run  = 1'b1;
                end
            end
            ST_RUN: begin
                if (fif.Halt)          w_next_state = ST_STOPPED;
                else if (fif.Pause)    w_next_state = ST_PAUSED;
                else if (r_cnt == '0)  w_strobe     = 1'b1;
                else                   w_dec        = 1'b1;
            end
            ST_PAUSED: begin
                if (fif.Halt)          w_next_state = ST_STOPPED;
                else if (!fif.Pause)   w_next_state = ST_RUN;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Period counter: loaded on start, reloaded with the current period on
    // each strobe, otherwise counts down while running.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst)           r_cnt <= '0;
        else if (w_start_run) r_cnt <= INIT_PERIOD - DIV_W'(1);
        else if (w_strobe)    r_cnt <= w_period - DIV_W'(1);
        else if (w_dec)       r_cnt <= r_cnt - DIV_W'(1);
    end

    // Gap tracker: zeros emitted since the last 1, saturating at MIN_GAP.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst)           r_gap <= GAP_MAX;
        else if (w_start_run) r_gap <= GAP_MAX;
        else if (w_strobe) begin
            if (w_bit)                r_gap <= '0;
            else if (r_gap < GAP_MAX) r_gap <= r_gap + GAP_W'(1);
        end
    end

    // Registered outputs: bit held between strobes, single-cycle strobe.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_bit     <= 1'b0;
            r_shift   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            if (w_strobe) r_bit <= w_bit;
            r_shift   <= w_strobe;
            r_running <= (w_next_state == ST_RUN) || (w_next_state == ST_PAUSED);
        end
    end

`ifdef FEEDER_SPEEDUP_EN
    localparam int SH_W = (SPEEDUP_EVERY < 2) ? 1 : $clog2(SPEEDUP_EVERY);
    localparam logic [SH_W-1:0] SH_LAST = SH_W'(SPEEDUP_EVERY - 1);

    logic [DIV_W-1:0] r_period;
    logic [SH_W-1:0]  r_shifts;
    logic [3:0]       r_level;
    logic [DIV_W-1:0] w_room;
    logic [DIV_W-1:0] w_period_dn;

    // Headroom above the floor; compared before subtracting so it never wraps.
    assign w_room      = (r_period > MIN_PERIOD) ? (r_period - MIN_PERIOD) : '0;
    assign w_period_dn = (w_room >= STEP) ? (r_period - STEP) : MIN_PERIOD;

    // Speed-up bookkeeping; the shortened period applies from the next reload.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_period <= INIT_PERIOD;
            r_shifts <= '0;
            r_level  <= '0;
        end else if (w_start_run) begin
            r_period <= INIT_PERIOD;
            r_shifts <= '0;
            r_level  <= '0;
        end else if (w_strobe) begin
            if (r_shifts == SH_LAST) begin
                r_shifts <= '0;
                r_period <= w_period_dn;
                if (r_level != LEVEL_MAX) r_level <= r_level + 4'd1;
            end else begin
                r_shifts <= r_shifts + SH_W'(1);
            end
        end
    end

    assign w_period = r_period;
    assign w_level  = r_level;
`else
    assign w_period = INIT_PERIOD;
    assign w_level  = 4'd0;
`endif

    assign fif.BitOut   = r_bit;
    assign fif.ShiftOut = r_shift;
    assign fif.Running  = r_running;
    assign fif.Level    = w_level;

endmodule
